accumulate_reduce_seq: RTL and testbench
========================================

Name: accumulate_reduce_seq

Overview:
- Multi-cycle, parametrised reduction engine for the execution environment (EV) u32 register space.
- Streams `length` consecutive words starting at `arr`, LANES words per beat, and folds them with a selectable operator (add, xor, and, or, min, max).
- Writes the scalar result to `dest` through the EV write port.
- Successor to the single-cycle combinational accumulate-reduce op: pipelined reads, multiple lanes, operator modes, overflow reporting, conditional skip.

Parameters:
- DATA_W, 32, word width of EV entries and of the accumulator.
- ADDR_W, 8, EV address width; also the width of the length field.
- LANES, 4, words delivered per read beat (power of two, 1..8).
- MAX_OUTSTANDING, 4, maximum read beats in flight.
- SATURATE, 0, 1 = add mode clamps to all-ones on unsigned overflow; 0 = wraps mod 2^DATA_W.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle command strobe; accepted only while busy=0
- arr  in  ADDR_W  first source address
- length  in  ADDR_W  number of words to reduce
- dest  in  ADDR_W  result address
- mode  in  3  0=add 1=xor 2=and 3=or 4=umin 5=umax; 6,7 reserved
- cond_pass  in  1  result of the conditional-flag check, sampled with start
- busy  out  1  command in progress
- done  out  1  one-cycle completion pulse
- skipped  out  1  qualifies done: no write was performed
- overflow  out  1  qualifies done: add mode carried out at least once
- rd_req  out  1  read beat request
- rd_addr  out  ADDR_W  base address of the beat
- rd_gnt  in  1  beat accepted when rd_req&rd_gnt
- rd_valid  in  1  beat data valid; returns in request order
- rd_data  in  LANES*DATA_W  lane k = word at rd_addr+k
- wr_en  out  1  one-cycle write strobe (always accepted)
- wr_addr  out  ADDR_W  equals latched dest
- wr_data  out  DATA_W  reduction result

Behaviour:
- Reset: all outputs 0, state IDLE, accumulator = 0, counters = 0. Reset mid-operation aborts immediately. No write or done is issued, and late rd_valid beats after reset are ignored.
- Clock/reset: one clock domain; reset asynchronous assert, synchronous deassert handled outside.
- IDLE: on start, latch arr/length/dest/mode.
  - cond_pass=0, length=0, or mode>=6: go to FINISH with skipped=1.
  - Otherwise: acc = identity(mode); busy=1 the cycle after start; go to RUN.
  - Identities: add/xor/or/umax = 0; and/umin = all-ones.
- RUN: request side and response side operate concurrently.
  - Request side: issue beats at arr, arr+LANES, ..., ceil(length/LANES) beats total. rd_req stays asserted until granted. No new request while in-flight = MAX_OUTSTANDING.
  - Response side: each rd_valid beat folds its lanes into acc in one cycle (tree or chain within the beat). On the final beat, lanes with index >= remaining words are replaced by the identity.
  - Simultaneous grant and valid in the same cycle update the in-flight count by net 0.
- Address wrap: rd_addr computed mod 2^ADDR_W; a source range crossing the top wraps to 0 and is not an error.
- Add mode arithmetic: sum of acc plus beat computed at DATA_W+log2(LANES)+1 bits. Any nonzero bits above DATA_W set sticky overflow. Result is clamped (SATURATE=1) or truncated (SATURATE=0).
- Min/max compare unsigned.
- WRITE: entered the cycle after the last beat is folded. wr_en=1 for one cycle with wr_addr=dest and wr_data=acc. Next state FINISH.
- FINISH: done=1 for one cycle; skipped/overflow valid the same cycle; busy drops the same cycle; return to IDLE.
  - skipped and overflow are held until the next start, then cleared.
- start while busy=1: ignored; no error reported.
- Latency (rd_gnt always 1, read latency L): last beat returns at cycle 1+ceil(length/LANES)+L-1; wr_en follows 1 cycle later; done 1 cycle after wr_en.
- dest inside the source range: allowed. Reads complete before the write, so the old values are used.

Decomposition:
- Shared package accumulate_reduce_pkg:
  - reduce_mode_e enum (ADD, XOR, AND, OR, UMIN, UMAX)
  - state enum (IDLE, RUN, WRITE, FINISH)
  - identity_f(mode) function
  - command struct {arr, length, dest, mode}
- Sub-module reduce_lane_fold: combinational fold of LANES words plus acc with lane mask. It returns the result and a carry-out flag. It is reused by a future vector-reduce op.

Test Plan:
- LANES=4, add, arr=0x10, length=5, EV[0x10..0x14]=1,2,3,4,5, dest=0x40, rd_gnt=1, L=1 -> 2 beats; second beat lanes 1..3 masked; wr_data=15 at wr_addr=0x40; done with overflow=0 and skipped=0.
- Add, length=2, words 0xFFFFFFFF and 0x2 -> SATURATE=0: wr_data=0x1, overflow=1; SATURATE=1: wr_data=0xFFFFFFFF, overflow=1.
- umin, length=3, words 7,3,9; then and, length=3, words 0xF0,0x3C,0xFF -> wr_data=3; then wr_data=0x30.
- cond_pass=0 with length=4 -> no rd_req, no wr_en; done and skipped asserted 1 cycle after start. Repeat with length=0 -> same response.
- length=16, rd_gnt toggling 0/1 every other cycle, L=3, xor of 0..15 -> in-flight never exceeds 4; wr_data=0x0; arr=0xFE wraps rd_addr to 0x02 on the second beat.
- reset_n pulsed low in RUN after 2 of 4 beats -> outputs 0 immediately; no wr_en or done. A fresh command afterwards completes correctly.

Source files
------------

// File: rtl/accumulate_reduce_pkg.sv
// Shared types and helpers for the EV accumulate-reduce engine and its lane folder.
package accumulate_reduce_pkg;

    localparam int EV_ADDR_W = 8;

    typedef enum logic [2:0] {
        MODE_ADD  = 3'd0,
        MODE_XOR  = 3'd1,
        MODE_AND  = 3'd2,
        MODE_OR   = 3'd3,
        MODE_UMIN = 3'd4,
        MODE_UMAX = 3'd5
    } reduce_mode_e;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        WRITE,
        FINISH
    } state_e;

    typedef struct packed {
        logic [EV_ADDR_W-1:0] arr;
        logic [EV_ADDR_W-1:0] length;
        logic [EV_ADDR_W-1:0] dest;
        reduce_mode_e         mode;
    } command_t;

    // Identity is either all-zeros or all-ones; returning the fill bit keeps this width-agnostic.
    function automatic logic identity_f(input reduce_mode_e m);
        return (m == MODE_AND) || (m == MODE_UMIN);
    endfunction

endpackage

// File: rtl/accumulate_reduce_seq_fold.sv
// Combinational fold of one read beat (LANES words, masked lanes as identity) into the accumulator.
module reduce_lane_fold
    import accumulate_reduce_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int LANES    = 4,
    parameter int SATURATE = 0
) (
    input  reduce_mode_e            mode,
    input  logic [DATA_W-1:0]       acc,
    input  logic [LANES*DATA_W-1:0] lanes,
    input  logic [LANES-1:0]        lane_mask,
    output logic [DATA_W-1:0]       result,
    output logic                    carry
);
    localparam int SUM_W = DATA_W + $clog2(LANES) + 1;

    function automatic logic [DATA_W-1:0] sat_f(input logic [SUM_W-1:0] sum);
        logic [DATA_W-1:0] r;
        r = sum[DATA_W-1:0];
        if ((SATURATE != 0) && (|sum[SUM_W-1:DATA_W])) r = '1;
        return r;
    endfunction

    logic [DATA_W-1:0] ident;
    logic [DATA_W-1:0] word;
    logic [DATA_W-1:0] chain;
    logic [SUM_W-1:0]  sum;

    always_comb begin
        ident = {DATA_W{identity_f(mode)}};
        sum   = SUM_W'(acc);
        chain = acc;
        word  = '0;
        for (int k = 0; k < LANES; k++) begin
            word = lane_mask[k] ? lanes[k*DATA_W +: DATA_W] : ident;
            sum  = sum + SUM_W'(word);
            case (mode)
                MODE_XOR:  chain = chain ^ word;
                MODE_AND:  chain = chain & word;
                MODE_OR:   chain = chain | word;
                MODE_UMIN: chain = (word < chain) ? word : chain;
                MODE_UMAX: chain = (word > chain) ? word : chain;
                default:   chain = chain;
            endcase
        end
        carry  = 1'b0;
        result = chain;
        if (mode == MODE_ADD) begin
            carry  = |sum[SUM_W-1:DATA_W];
            result = sat_f(sum);
        end
    end

endmodule

// File: rtl/accumulate_reduce_seq.sv
// Multi-lane pipelined reduction over a range of EV words; result written back to dest.
module accumulate_reduce_seq
    import accumulate_reduce_pkg::*;
#(
    parameter int DATA_W          = 32,
    parameter int ADDR_W          = EV_ADDR_W,
    parameter int LANES           = 4,
    parameter int MAX_OUTSTANDING = 4,
    parameter int SATURATE        = 0
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic [ADDR_W-1:0]       arr,
    input  logic [ADDR_W-1:0]       length,
    input  logic [ADDR_W-1:0]       dest,
    input  logic [2:0]              mode,
    input  logic                    cond_pass,
    output logic                    busy,
    output logic                    done,
    output logic                    skipped,
    output logic                    overflow,
    output logic                    rd_req,
    output logic [ADDR_W-1:0]       rd_addr,
    input  logic                    rd_gnt,
    input  logic                    rd_valid,
    input  logic [LANES*DATA_W-1:0] rd_data,
    output logic                    wr_en,
    output logic [ADDR_W-1:0]       wr_addr,
    output logic [DATA_W-1:0]       wr_data
);
    localparam int OFF_W = ADDR_W + 1;
    localparam int IF_W  = $clog2(MAX_OUTSTANDING + 1);

    state_e            state_q, state_d;
    command_t          cmd_q;
    logic [DATA_W-1:0] acc_q;
    logic [OFF_W-1:0]  req_off_q, rsp_off_q, len_ext;
    logic [IF_W-1:0]   inflight_q;
    logic              skipped_q, overflow_q;
    logic              accept, skip, grant, fold_en, last_beat;
    logic [LANES-1:0]  lane_mask;
    logic [DATA_W-1:0] fold_result;
    logic              fold_carry;

    // Offsets are one bit wider than addresses so the final partial beat cannot wrap the compare.
    assign len_ext   = {1'b0, cmd_q.length};
    assign rd_req    = (state_q == RUN) && (req_off_q < len_ext)
                       && (inflight_q < IF_W'(MAX_OUTSTANDING));
    assign rd_addr   = cmd_q.arr + req_off_q[ADDR_W-1:0];
    assign grant     = rd_req && rd_gnt;
    assign fold_en   = (state_q == RUN) && rd_valid && (rsp_off_q < len_ext);
    assign last_beat = (rsp_off_q + OFF_W'(LANES)) >= len_ext;

    always_comb begin
        for (int k = 0; k < LANES; k++) lane_mask[k] = (rsp_off_q + OFF_W'(k)) < len_ext;
    end

    reduce_lane_fold #(
        .DATA_W  (DATA_W),
        .LANES   (LANES),
        .SATURATE(SATURATE)
    ) u_fold (
        .mode     (cmd_q.mode),
        .acc      (acc_q),
        .lanes    (rd_data),
        .lane_mask(lane_mask),
        .result   (fold_result),
        .carry    (fold_carry)
    );

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        skip    = 1'b0;
        case (state_q)
            IDLE, FINISH: begin
                state_d = IDLE;
                if (start) begin
                    accept  = 1'b1;
                    skip    = !cond_pass || (length == '0) || (mode >= 3'd6);
                    state_d = skip ? FINISH : RUN;
                end
            end
            RUN:     if (fold_en && last_beat) state_d = WRITE;
            WRITE:   state_d = FINISH;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cmd_q      <= '0;
            acc_q      <= '0;
            req_off_q  <= '0;
            rsp_off_q  <= '0;
            inflight_q <= '0;
            skipped_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                cmd_q.arr    <= arr;
                cmd_q.length <= length;
                cmd_q.dest   <= dest;
                cmd_q.mode   <= reduce_mode_e'(mode);
                acc_q        <= {DATA_W{identity_f(reduce_mode_e'(mode))}};
                req_off_q    <= '0;
                rsp_off_q    <= '0;
                inflight_q   <= '0;
                skipped_q    <= skip;
                overflow_q   <= 1'b0;
            end else begin
                if (grant) req_off_q <= req_off_q + OFF_W'(LANES);
                if (fold_en) begin
                    rsp_off_q <= rsp_off_q + OFF_W'(LANES);
                    acc_q     <= fold_result;
                    if (fold_carry) overflow_q <= 1'b1;
                end
                if (grant && !fold_en)      inflight_q <= inflight_q + 1'b1;
                else if (!grant && fold_en) inflight_q <= inflight_q - 1'b1;
            end
        end
    end

    assign busy     = (state_q == RUN) || (state_q == WRITE);
    assign done     = (state_q == FINISH);
    assign skipped  = skipped_q;
    assign overflow = overflow_q;
    assign wr_en    = (state_q == WRITE);
    assign wr_addr  = cmd_q.dest;
    assign wr_data  = acc_q;

endmodule

// File: tb/tb_accumulate_reduce_seq.sv
// Directed bench for accumulate_reduce_seq with an in-order EV read responder.
module tb_accumulate_reduce_seq;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         start;
    logic [7:0]   arr, length, dest;
    logic [2:0]   mode;
    logic         cond_pass;
    logic         busy, done, skipped, overflow, rd_req, wr_en;
    logic [7:0]   rd_addr, wr_addr;
    logic         rd_gnt, rd_valid;
    logic [127:0] rd_data;
    logic [31:0]  wr_data;
    logic         busy_s, done_s, skipped_s, overflow_s, rd_req_s, wr_en_s;
    logic [7:0]   rd_addr_s, wr_addr_s;
    logic [31:0]  wr_data_s;

    always #5 clk = ~clk;

    accumulate_reduce_seq #(.DATA_W(32), .ADDR_W(8), .LANES(4), .MAX_OUTSTANDING(4), .SATURATE(0)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .arr(arr), .length(length), .dest(dest),
        .mode(mode), .cond_pass(cond_pass), .busy(busy), .done(done), .skipped(skipped),
        .overflow(overflow), .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
        .rd_valid(rd_valid), .rd_data(rd_data), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data));

    // Saturating twin follows the same stream; only its result and flags are inspected.
    accumulate_reduce_seq #(.DATA_W(32), .ADDR_W(8), .LANES(4), .MAX_OUTSTANDING(4), .SATURATE(1)) dut_sat (
        .clk(clk), .reset_n(reset_n), .start(start), .arr(arr), .length(length), .dest(dest),
        .mode(mode), .cond_pass(cond_pass), .busy(busy_s), .done(done_s), .skipped(skipped_s),
        .overflow(overflow_s), .rd_req(rd_req_s), .rd_addr(rd_addr_s), .rd_gnt(rd_gnt),
        .rd_valid(rd_valid), .rd_data(rd_data), .wr_en(wr_en_s), .wr_addr(wr_addr_s), .wr_data(wr_data_s));

    logic [31:0] ev [256];
    int          lat = 1;
    logic        gnt_toggle = 1'b0;

    typedef struct { logic [7:0] addr; int due; } pend_t;
    pend_t       pend_q[$];
    logic [7:0]  gnt_log[$];
    int          tb_inflight;
    int          rsp_cnt;

    initial begin : responder
        int cyc;
        pend_t p;
        logic [7:0] a;
        cyc = 0; tb_inflight = 0; rsp_cnt = 0;
        rd_gnt = 1'b0; rd_valid = 1'b0; rd_data = '0;
        forever begin
            @(posedge clk);
            if (!reset_n) begin
                pend_q.delete();
            end else begin
                if (rd_req && rd_gnt) begin
                    p.addr = rd_addr; p.due = cyc + lat;
                    pend_q.push_back(p);
                    gnt_log.push_back(rd_addr);
                end
                if (rd_valid && pend_q.size() > 0) begin
                    void'(pend_q.pop_front());
                    rsp_cnt++;
                end
            end
            cyc++;
            tb_inflight = pend_q.size();
            #1;
            rd_gnt = gnt_toggle ? !rd_gnt : 1'b1;
            rd_valid = 1'b0;
            if (reset_n && pend_q.size() > 0 && pend_q[0].due <= cyc) begin
                rd_valid = 1'b1;
                for (int k = 0; k < 4; k++) begin
                    a = pend_q[0].addr + 8'(k);
                    rd_data[k*32 +: 32] = ev[a];
                end
            end
        end
    end

    int n_cmp = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    logic [31:0] got_data, got_data_s;
    logic [7:0]  got_addr;
    logic        got_skip, got_ovf, got_ovf_s, req_seen, done_seen;
    int          wr_cnt, done_cyc, max_if;

    task automatic run_cmd(input logic [7:0] a, input logic [7:0] l, input logic [7:0] d,
                           input logic [2:0] m, input logic cp);
        int cycles;
        @(negedge clk);
        arr = a; length = l; dest = d; mode = m; cond_pass = cp; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cycles = 1; wr_cnt = 0; req_seen = 0; done_seen = 0; done_cyc = -1; max_if = 0;
        got_data = '0; got_data_s = '0; got_addr = '0; got_skip = 0; got_ovf = 0; got_ovf_s = 0;
        while (!done_seen && cycles < 400) begin
            if (tb_inflight > max_if) max_if = tb_inflight;
            if (rd_req) req_seen = 1'b1;
            if (wr_en) begin
                wr_cnt++; got_data = wr_data; got_addr = wr_addr; got_data_s = wr_data_s;
            end
            if (done) begin
                done_seen = 1'b1; done_cyc = cycles;
                got_skip = skipped; got_ovf = overflow; got_ovf_s = overflow_s;
            end else begin
                @(negedge clk);
                cycles++;
            end
        end
        check("done_within_budget", done_seen, 1);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int waited, seen;
        for (int i = 0; i < 256; i++) ev[i] = 32'h0;
        for (int i = 0; i < 16; i++) ev[(8'hFE + i) & 8'hFF] = 32'(i);
        ev[8'h10] = 1; ev[8'h11] = 2; ev[8'h12] = 3; ev[8'h13] = 4; ev[8'h14] = 5;
        ev[8'h20] = 32'hFFFF_FFFF; ev[8'h21] = 32'h2;
        ev[8'h30] = 7; ev[8'h31] = 3; ev[8'h32] = 9;
        ev[8'h38] = 32'hF0; ev[8'h39] = 32'h3C; ev[8'h3A] = 32'hFF;
        for (int i = 0; i < 32; i++) ev[8'h80 + i] = 32'(i + 1);

        reset_n = 1'b0; start = 0; arr = 0; length = 0; dest = 0; mode = 0; cond_pass = 0;
        repeat (3) @(negedge clk);
        check("reset_outputs",
              {busy, done, skipped, overflow, rd_req, rd_addr, wr_en, wr_addr, wr_data}, 0);
        reset_n = 1'b1;

        run_cmd(8'h10, 8'd5, 8'h40, 3'd0, 1'b1);
        check("add5_data", got_data, 15);
        check("add5_addr", got_addr, 8'h40);
        check("add5_wr_count", wr_cnt, 1);
        check("add5_done_cycle", done_cyc, 5);
        check("add5_flags", {got_skip, got_ovf}, 2'b00);

        run_cmd(8'h20, 8'd2, 8'h41, 3'd0, 1'b1);
        check("wrap_add_data", got_data, 32'h1);
        check("wrap_add_ovf", got_ovf, 1);
        check("sat_add_data", got_data_s, 32'hFFFF_FFFF);
        check("sat_add_ovf", got_ovf_s, 1);

        run_cmd(8'h30, 8'd3, 8'h42, 3'd4, 1'b1);
        check("umin_data", got_data, 3);
        run_cmd(8'h38, 8'd3, 8'h43, 3'd2, 1'b1);
        check("and_data", got_data, 32'h30);
        check("and_ovf_cleared", got_ovf, 0);

        run_cmd(8'h10, 8'd4, 8'h44, 3'd0, 1'b0);
        check("condfail_no_req", req_seen, 0);
        check("condfail_no_wr", wr_cnt, 0);
        check("condfail_done_cycle", done_cyc, 1);
        check("condfail_skipped", got_skip, 1);
        run_cmd(8'h10, 8'd0, 8'h44, 3'd0, 1'b1);
        check("len0_no_req", req_seen, 0);
        check("len0_no_wr", wr_cnt, 0);
        check("len0_done_cycle", done_cyc, 1);
        check("len0_skipped", got_skip, 1);
        run_cmd(8'h10, 8'd4, 8'h44, 3'd6, 1'b1);
        check("mode6_skipped", {got_skip, req_seen, wr_cnt[0]}, 3'b100);

        lat = 3; gnt_toggle = 1'b1;
        seen = gnt_log.size();
        run_cmd(8'hFE, 8'd16, 8'h45, 3'd1, 1'b1);
        check("xor16_data", got_data, 0);
        check("xor16_inflight_le4", max_if <= 4, 1);
        check("xor16_beats", gnt_log.size() - seen, 4);
        check("xor16_second_addr", (gnt_log.size() > seen + 1) ? gnt_log[seen + 1] : 8'hxx, 8'h02);

        lat = 8; gnt_toggle = 1'b0;
        run_cmd(8'h80, 8'd32, 8'h46, 3'd0, 1'b1);
        check("add32_data", got_data, 528);
        check("add32_inflight_cap", max_if, 4);

        lat = 1;
        seen = rsp_cnt;
        @(negedge clk);
        arr = 8'h80; length = 8'd16; dest = 8'h47; mode = 3'd0; cond_pass = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waited = 0;
        while (rsp_cnt < seen + 2 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check("rst_two_beats_seen", waited < 50, 1);
        check("rst_still_busy", busy, 1);
        #2 reset_n = 1'b0;
        #1;
        check("rst_mid_outputs",
              {busy, done, skipped, overflow, rd_req, rd_addr, wr_en, wr_addr, wr_data}, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        wr_cnt = 0; seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (wr_en) wr_cnt++;
            if (done) seen++;
        end
        check("rst_no_write_or_done", {wr_cnt[3:0], seen[3:0]}, 0);

        run_cmd(8'h10, 8'd5, 8'h48, 3'd0, 1'b1);
        check("post_rst_data", got_data, 15);
        check("post_rst_addr", got_addr, 8'h48);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
